// File: rtl/sample_readout_pkg.sv
// Shared constants and FSM state encoding for the sample FIFO readout block.
package sample_readout_pkg;

  // Frame delimiters on the TX stream
  localparam logic [7:0] HdrByte = 8'hA5;
  localparam logic [7:0] TrlOk   = 8'h5A;
  localparam logic [7:0] TrlErr  = 8'hEE;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StHdr   = 3'd2,
    StRd    = 3'd3,
    StLat   = 3'd4,
    StSend  = 3'd5,
    StTrl   = 3'd6
  } state_e;

endpackage

// File: rtl/sample_readout.sv
// Drains one full sample FIFO per trigger and streams it to the serial TX as
// header, FRAME_LEN samples and a trailer over a valid/ready byte handshake.
module sample_readout
  import sample_readout_pkg::*;
#(
  parameter int unsigned          DATA_SIZE = 8,
  parameter int unsigned          FRAME_LEN = 256,
  parameter logic [DATA_SIZE-1:0] HDR_BYTE  = DATA_SIZE'(HdrByte)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trigger_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_SIZE-1:0] fifo_data_i,
  output logic                 fifo_r_en_o,
  output logic [DATA_SIZE-1:0] tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 underrun_o
);

  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_trig_seen;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_inc;
  logic [DATA_SIZE-1:0] r_tx_data;
  logic                 r_underrun;
  logic                 w_enter_hdr;
  logic                 w_rd_en;

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_enter_hdr = (r_state == StArmed) && fifo_full_i;

  // Next-state decode; the FIFO strobe is only raised when data is present
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      StIdle:  if (r_trig_seen || trigger_i) w_state_nxt = StArmed;
      StArmed: if (fifo_full_i) w_state_nxt = StHdr;
      StHdr:   if (tx_ready_i) w_state_nxt = StRd;
      StRd: begin
        if (fifo_empty_i) begin
          w_state_nxt = StTrl;
        end else begin
          w_rd_en     = 1'b1;
          w_state_nxt = StLat;
        end
      end
      StLat:   w_state_nxt = StSend;
      StSend: begin
        if (tx_ready_i) begin
          w_state_nxt = (w_cnt_inc == CntW'(FRAME_LEN)) ? StTrl : StRd;
        end
      end
      StTrl:   if (tx_ready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trigger latch: only listens before a frame starts, so triggers while busy are dropped
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_trig_seen <= 1'b0;
    end else if (w_enter_hdr) begin
      r_trig_seen <= 1'b0;
    end else if (trigger_i && (r_state == StIdle || r_state == StArmed)) begin
      r_trig_seen <= 1'b1;
    end
  end

  // Sample counter: cleared at frame start, advanced on each accepted sample
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (w_enter_hdr) begin
      r_cnt <= '0;
    end else if (r_state == StSend && tx_ready_i) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // TX holding register: FIFO read data is valid in the cycle after the strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_data <= '0;
    end else if (r_state == StLat) begin
      r_tx_data <= fifo_data_i;
    end
  end

  // Sticky underrun flag, reported in the trailer and held until the next frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_underrun <= 1'b0;
    end else if (w_enter_hdr) begin
      r_underrun <= 1'b0;
    end else if (r_state == StRd && fifo_empty_i) begin
      r_underrun <= 1'b1;
    end
  end

  // Output decode; data is a function of state so it cannot change while valid is held
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    case (r_state)
      StHdr: begin
        tx_valid_o = 1'b1;
        tx_data_o  = HDR_BYTE;
      end
      StSend: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_tx_data;
      end
      StTrl: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_underrun ? DATA_SIZE'(TrlErr) : DATA_SIZE'(TrlOk);
      end
      default: ;
    endcase
  end

  assign fifo_r_en_o = w_rd_en;
  assign busy_o      = (r_state != StIdle);
  assign underrun_o  = r_underrun;

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout with FRAME_LEN=4 and a small FIFO model.
module tb_sample_readout;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       trigger_i;
  logic       fifo_full_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_r_en_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       underrun_o;

  int checks = 0;
  int errors = 0;

  // FIFO model: the initial block writes, the clocked block reads
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         n_bad_rd = 0;
  logic       force_full = 1'b0;

  assign fifo_full_i  = ((wr_ptr - rd_ptr) == 4) || force_full;
  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_r_en_o) begin
      if (wr_ptr == rd_ptr) begin
        n_bad_rd <= n_bad_rd + 1;
      end else begin
        fifo_data_i <= mem[rd_ptr % 64];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  sample_readout #(
    .DATA_SIZE(8),
    .FRAME_LEN(4),
    .HDR_BYTE (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .trigger_i   (trigger_i),
    .fifo_full_i (fifo_full_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_r_en_o (fifo_r_en_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o)
  );

  // Results of the most recent run_frame
  logic [63:0] got_vec;
  int          got_n;
  int          n_ren;
  int          n_frame;
  int          n_stab;
  bit          timed_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  // Pulse trigger, then run until busy drops, logging every accepted TX word
  task automatic run_frame(input bit toggle_rdy, input bit retrig);
    bit         started;
    bit         seen_valid;
    bit         prev_hold;
    logic [7:0] prev_data;
    got_vec   = '0;
    got_n     = 0;
    n_ren     = 0;
    n_frame   = 0;
    n_stab    = 0;
    timed_out = 1'b1;
    started    = 1'b0;
    seen_valid = 1'b0;
    prev_hold  = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      trigger_i  = (cyc == 0) || (retrig && cyc == 8);
      tx_ready_i = toggle_rdy ? (cyc % 3 == 2) : 1'b1;
      if (busy_o) started = 1'b1;
      if (started && !busy_o) begin
        timed_out = 1'b0;
        break;
      end
      if (prev_hold && (!tx_valid_o || tx_data_o !== prev_data)) n_stab++;
      if (tx_valid_o) seen_valid = 1'b1;
      if (seen_valid && busy_o) n_frame++;
      if (fifo_r_en_o) n_ren++;
      if (tx_valid_o && tx_ready_i) begin
        got_vec = {got_vec[55:0], tx_data_o};
        got_n++;
      end
      prev_hold = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
    end
    trigger_i  = 1'b0;
    tx_ready_i = 1'b1;
  endtask

  initial begin
    int   idle_ren;
    int   rd_before;
    bit   found;
    rst_i      = 1'b0;
    trigger_i  = 1'b0;
    tx_ready_i = 1'b0;
    fifo_data_i = '0;
    #1;
    check("reset_valid", {63'd0, tx_valid_o}, 64'd0);
    check("reset_data", {56'd0, tx_data_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_ren", {63'd0, fifo_r_en_o}, 64'd0);
    check("reset_underrun", {63'd0, underrun_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i      = 1'b1;
    tx_ready_i = 1'b1;

    // Full FIFO but no trigger: must stay idle
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    idle_ren = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_r_en_o || tx_valid_o || busy_o) idle_ren++;
    end
    check("notrig_idle_activity", idle_ren, 0);
    check("notrig_no_reads", rd_ptr, 0);

    // Basic frame with ready always high
    run_frame(1'b0, 1'b0);
    check("f1_timeout", {63'd0, timed_out}, 64'd0);
    check("f1_nbytes", got_n, 6);
    check("f1_stream", got_vec, 64'h0000_A511_2233_445A);
    check("f1_ren", n_ren, 4);
    check("f1_frame_cycles", n_frame, 14);
    check("f1_underrun", {63'd0, underrun_o}, 64'd0);
    check("f1_fifo_drained", wr_ptr - rd_ptr, 0);

    // Same data with ready high only one cycle in three
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    run_frame(1'b1, 1'b0);
    check("f2_timeout", {63'd0, timed_out}, 64'd0);
    check("f2_nbytes", got_n, 6);
    check("f2_stream", got_vec, 64'h0000_A511_2233_445A);
    check("f2_ren", n_ren, 4);
    check("f2_hold_stable", n_stab, 0);

    // Underrun: only two samples present, full flag forced
    load(8'h3C); load(8'hC3);
    force_full = 1'b1;
    run_frame(1'b0, 1'b0);
    force_full = 1'b0;
    check("f3_timeout", {63'd0, timed_out}, 64'd0);
    check("f3_nbytes", got_n, 4);
    check("f3_stream", got_vec, 64'h0000_0000_A53C_C3EE);
    check("f3_ren", n_ren, 2);
    check("f3_underrun_set", {63'd0, underrun_o}, 64'd1);
    repeat (4) @(negedge clk);
    check("f3_underrun_sticky", {63'd0, underrun_o}, 64'd1);

    // Second trigger mid-frame is dropped; underrun clears with the new frame
    load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    run_frame(1'b0, 1'b1);
    check("f5_timeout", {63'd0, timed_out}, 64'd0);
    check("f5_stream", got_vec, 64'h0000_A501_0203_045A);
    check("f5_underrun_cleared", {63'd0, underrun_o}, 64'd0);
    idle_ren = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_o || tx_valid_o || fifo_r_en_o) idle_ren++;
    end
    check("f5_no_queued_frame", idle_ren, 0);

    // Reset while the second sample is waiting in SEND
    load(8'h55); load(8'h66); load(8'h77); load(8'h88);
    rd_before = rd_ptr;
    found     = 1'b0;
    tx_ready_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid_o && tx_data_o == 8'h66) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("f4_reached_send2", {63'd0, found}, 64'd1);
    rst_i = 1'b0;
    #1;
    check("f4_rst_valid", {63'd0, tx_valid_o}, 64'd0);
    check("f4_rst_data", {56'd0, tx_data_o}, 64'd0);
    check("f4_rst_busy", {63'd0, busy_o}, 64'd0);
    check("f4_rst_ren", {63'd0, fifo_r_en_o}, 64'd0);
    check("f4_reads_before_rst", rd_ptr - rd_before, 2);
    @(negedge clk);
    rst_i = 1'b1;
    // Leftover 77,88 stay in the FIFO; top it up to full
    load(8'h99); load(8'hAA);
    run_frame(1'b0, 1'b0);
    check("f4_timeout", {63'd0, timed_out}, 64'd0);
    check("f4_stream", got_vec, 64'h0000_A577_8899_AA5A);
    check("f4_ren", n_ren, 4);

    check("never_read_empty", n_bad_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
